switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Upstream stage of the RGB PWM controller: takes raw board slide switches and delivers clean, glitch-free 6-bit duty-select codes on its SW input.
- Each bit is synchronised to clock, then accepted only after staying stable for STABLE_TICKS consecutive prescaler ticks.
- The tick comes from the existing prescaler clock_enable, typically the 32 kHz tick.
- A one-cycle change pulse per bit is also provided for downstream status or event logic.

Parameters:
- WIDTH, 6, number of switch bits.
- SYNC_STAGES, 2, flip-flop synchroniser depth per bit; must be >= 2.
- STABLE_TICKS, 32, consecutive ticks an input must hold before acceptance; must be >= 1. At 32 kHz this is 1 ms.
- RESET_VALUE, '0, WIDTH-bit value loaded into sw_clean at reset.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; reset asserted when 0.
- tick  input  1  single-cycle sampling enable from the prescaler.
- sw_raw  input  WIDTH  asynchronous raw switch levels.
- sw_clean  output  WIDTH  debounced switch levels; connects to the rgb_controller SW input.
- sw_changed  output  WIDTH  per-bit one-clock pulse when the sw_clean bit updates.
- any_changed  output  1  OR of sw_changed, registered in the same cycle as sw_changed.

Behaviour:
- Reset (reset==0, asynchronous, any time):
  - all synchroniser flops <= 0;
  - sw_clean <= RESET_VALUE;
  - all counters <= 0;
  - sw_changed <= 0 and any_changed <= 0.
  - Release is synchronous to clock.
- Mid-operation reset abandons any partial count. After release, a bit that differs from RESET_VALUE must requalify over the full STABLE_TICKS.
- Synchroniser: sync[i] is sw_raw[i] after SYNC_STAGES clock edges. It runs every cycle, independent of tick.
- Per bit, define mismatch = (sync[i] != sw_clean[i]). Rules evaluated every clock edge, in priority order:
  1. mismatch==0: cnt <= 0. This applies every cycle, tick or not. A bounce back to the accepted level cancels the count immediately.
  2. mismatch==1 && tick==1 && cnt==STABLE_TICKS-1: sw_clean[i] <= sync[i]; cnt <= 0; sw_changed[i] <= 1.
  3. mismatch==1 && tick==1 otherwise: cnt <= cnt+1.
  4. mismatch==1 && tick==0: cnt holds.
- sw_changed[i] is 1 for exactly one clock after rule 2 and 0 in all other cycles. This holds even when tick is held high continuously.
- Counter width is max(1, $clog2(STABLE_TICKS)). The counter never exceeds STABLE_TICKS-1 and has no wrap-around path.
- Latency from a clean sw_raw edge to sw_clean: SYNC_STAGES clocks, plus STABLE_TICKS ticks, plus 1 clock. The first counted tick is the first tick on which mismatch is seen.
- STABLE_TICKS==1: the bit is accepted on the first tick with mismatch.
- tick held constantly 1: the block degenerates to a cycle-count debouncer; legal.
- Bits are fully independent. Simultaneous changes on several bits each follow their own count, and may update in the same cycle; any_changed is then a single pulse.
- Raw input toggling faster than the qualification period: sw_clean never changes and no pulse is generated.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package switch_pkg holds:
  - localparam SW_WIDTH = 6;
  - DEBOUNCE_TICKS_1MS = 32, the tick count at the 32 kHz prescaler rate;
  - typedef logic [SW_WIDTH-1:0] sw_vec_t.
- Sub-module debounce_bit: one bit's synchroniser, counter and accept/pulse logic, with the same parameters minus WIDTH.
- switch_debouncer instantiates WIDTH copies in a generate loop and forms any_changed.

Test Plan:
- Bench setup for all scenarios: STABLE_TICKS=4, tick every 4th clock.
- Reset: hold reset=0 for 5 clocks with sw_raw=6'h3F -> sw_clean==6'h00 and sw_changed==0 throughout reset. After release with sw_raw held, sw_clean becomes 6'h3F after 2 + 4 ticks + 1 clocks, with a one-cycle sw_changed==6'h3F and any_changed==1.
- Clean edge: sw_raw[0] 0->1 and held -> sw_clean[0] rises exactly on the 4th tick after sync, plus 1 clock. sw_changed[0] pulses once; other bits stay 0.
- Bounce: sw_raw[2] toggles high for 2 ticks, then low for 1, then high and held -> the count restarts at the bounce. sw_clean[2] rises only after 4 uninterrupted ticks; exactly one pulse.
- Glitch rejection: a 3-clock pulse on sw_raw[5] between ticks -> sw_clean unchanged and no sw_changed.
- Simultaneous bits, then async reset: sw_raw 6'h00->6'h15 -> sw_clean==6'h15 in one cycle, with sw_changed==6'h15 in one cycle. Then assert reset mid-count after 2 ticks of a change to 6'h00 -> immediate sw_clean==RESET_VALUE. After release, full requalification.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch-input constants and types for the RGB PWM front end.
// The 1 ms debounce window assumes the 32 kHz prescaler tick.
package switch_pkg;
    localparam int SW_WIDTH           = 6;
    localparam int DEBOUNCE_TICKS_1MS = 32;

    typedef logic [SW_WIDTH-1:0] sw_vec_t;
endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser, tick-qualified stability counter and accept pulse.
// A bounce back to the accepted level clears the count on any clock, not just on ticks.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   STABLE_TICKS = DEBOUNCE_TICKS_1MS,
    parameter logic RESET_VALUE  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic sw_raw,
    output logic sw_clean,
    output logic sw_changed,
    output logic accept
);

    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_bit;
    logic                   mismatch;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign mismatch = sync_bit ^ sw_clean;
    // Combinational so the top can register its OR alongside sw_changed.
    assign accept   = mismatch & tick & (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            sw_clean   <= RESET_VALUE;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= accept;
            if (!mismatch || accept) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept) begin
                sw_clean <= sync_bit;
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw board slide switches into clean duty-select codes.
// Bits are independent; any_changed is a single pulse even when several bits land together.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int               WIDTH        = SW_WIDTH,
    parameter int               SYNC_STAGES  = 2,
    parameter int               STABLE_TICKS = DEBOUNCE_TICKS_1MS,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_changed
);

    logic [WIDTH-1:0] accept;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS),
            .RESET_VALUE (RESET_VALUE[g])
        ) u_bit (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .sw_raw    (sw_raw[g]),
            .sw_clean  (sw_clean[g]),
            .sw_changed(sw_changed[g]),
            .accept    (accept[g])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            any_changed <= 1'b0;
        end else begin
            any_changed <= |accept;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed vector table, hand-written corner sequences
// and randomized stimulus compared every cycle against a behavioural model.
module tb_switch_debouncer;

    localparam int W  = 6;
    localparam int ST = 4;
    localparam int SS = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         tick;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_changed;
    logic         any_changed;

    switch_debouncer #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .STABLE_TICKS(ST),
        .RESET_VALUE (6'h00)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_changed (sw_changed),
        .any_changed(any_changed)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int phase    = 0;

    // Behavioural model: raw samples travel through a fixed-length delay queue;
    // each bit counts ticks seen during an unbroken run of disagreement.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_clean;
    logic [W-1:0] m_changed;
    logic         m_any;
    int           m_run[W];

    task automatic model_reset();
        m_clean   = 6'h00;
        m_changed = '0;
        m_any     = 1'b0;
        for (int b = 0; b < W; b++) m_run[b] = 0;
        m_hist.delete();
        for (int k = 0; k < SS; k++) m_hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [W-1:0] sync_v;
        if (!reset) begin
            model_reset();
            return;
        end
        sync_v = m_hist.pop_front();
        m_hist.push_back(sw_raw);
        m_changed = '0;
        for (int b = 0; b < W; b++) begin
            if (sync_v[b] == m_clean[b]) begin
                m_run[b] = 0;
            end else if (tick) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] == ST) begin
                    m_clean[b]   = sync_v[b];
                    m_run[b]     = 0;
                    m_changed[b] = 1'b1;
                end
            end
        end
        m_any = |m_changed;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic rst_v, input logic [W-1:0] raw, input logic tk);
        reset  = rst_v;
        sw_raw = raw;
        tick   = tk;
        @(posedge clock);
        model_edge();
        #1;
        chk("model_sw_clean", 32'(sw_clean), 32'(m_clean));
        chk("model_sw_changed", 32'(sw_changed), 32'(m_changed));
        chk("model_any_changed", 32'(any_changed), 32'(m_any));
        @(negedge clock);
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] raw;
        int           n;
        logic [W-1:0] clean;
        logic [W-1:0] chg;
        int           anyc;
        logic         restart;
    } vec_t;

    vec_t tbl[24];

    task automatic apply_row(input int idx);
        logic [W-1:0] acc_chg;
        int           any_cnt;
        acc_chg = '0;
        any_cnt = 0;
        if (tbl[idx].restart) phase = 0;
        for (int s = 0; s < tbl[idx].n; s++) begin
            step(tbl[idx].rst, tbl[idx].raw, phase == 3);
            phase   = (phase + 1) % 4;
            acc_chg = acc_chg | sw_changed;
            if (any_changed) any_cnt++;
        end
        chk($sformatf("row%0d_clean", idx), 32'(sw_clean), 32'(tbl[idx].clean));
        chk($sformatf("row%0d_pulses", idx), 32'(acc_chg), 32'(tbl[idx].chg));
        chk($sformatf("row%0d_any_count", idx), 32'(any_cnt), 32'(tbl[idx].anyc));
    endtask

    initial begin
        logic [W-1:0] rnd_raw;
        logic         rnd_tick;
        int           mode;

        //            rst   raw    n   clean  chg  any restart
        tbl[0]  = '{1'b0, 6'h3F,  5, 6'h00, 6'h00, 0, 1'b1};
        tbl[1]  = '{1'b1, 6'h3F, 15, 6'h00, 6'h00, 0, 1'b1};
        tbl[2]  = '{1'b1, 6'h3F,  1, 6'h3F, 6'h3F, 1, 1'b0};
        tbl[3]  = '{1'b1, 6'h3F,  4, 6'h3F, 6'h00, 0, 1'b0};
        tbl[4]  = '{1'b1, 6'h3E, 16, 6'h3E, 6'h01, 1, 1'b0};
        tbl[5]  = '{1'b1, 6'h3F, 15, 6'h3E, 6'h00, 0, 1'b0};
        tbl[6]  = '{1'b1, 6'h3F,  1, 6'h3F, 6'h01, 1, 1'b0};
        tbl[7]  = '{1'b1, 6'h3F,  4, 6'h3F, 6'h00, 0, 1'b0};
        tbl[8]  = '{1'b1, 6'h3B, 16, 6'h3B, 6'h04, 1, 1'b0};
        tbl[9]  = '{1'b1, 6'h3B,  4, 6'h3B, 6'h00, 0, 1'b0};
        tbl[10] = '{1'b1, 6'h3F,  8, 6'h3B, 6'h00, 0, 1'b0};
        tbl[11] = '{1'b1, 6'h3B,  4, 6'h3B, 6'h00, 0, 1'b0};
        tbl[12] = '{1'b1, 6'h3F, 15, 6'h3B, 6'h00, 0, 1'b0};
        tbl[13] = '{1'b1, 6'h3F,  1, 6'h3F, 6'h04, 1, 1'b0};
        tbl[14] = '{1'b1, 6'h3F,  4, 6'h3F, 6'h00, 0, 1'b0};
        tbl[15] = '{1'b1, 6'h1F,  3, 6'h3F, 6'h00, 0, 1'b0};
        tbl[16] = '{1'b1, 6'h3F, 13, 6'h3F, 6'h00, 0, 1'b0};
        tbl[17] = '{1'b1, 6'h00, 16, 6'h00, 6'h3F, 1, 1'b0};
        tbl[18] = '{1'b1, 6'h15, 15, 6'h00, 6'h00, 0, 1'b0};
        tbl[19] = '{1'b1, 6'h15,  1, 6'h15, 6'h15, 1, 1'b0};
        tbl[20] = '{1'b1, 6'h00,  8, 6'h15, 6'h00, 0, 1'b0};
        tbl[21] = '{1'b0, 6'h00,  4, 6'h00, 6'h00, 0, 1'b1};
        tbl[22] = '{1'b1, 6'h15, 15, 6'h00, 6'h00, 0, 1'b1};
        tbl[23] = '{1'b1, 6'h15,  1, 6'h15, 6'h15, 1, 1'b0};

        reset  = 1'b0;
        tick   = 1'b0;
        sw_raw = 6'h3F;
        model_reset();
        @(negedge clock);

        for (int r = 0; r <= 20; r++) apply_row(r);

        // Reset mid-count must clear sw_clean without waiting for a clock edge.
        reset = 1'b0;
        #1;
        chk("async_reset_clean", 32'(sw_clean), 32'h00);
        chk("async_reset_changed", 32'(sw_changed), 32'h00);
        model_reset();
        @(negedge clock);

        for (int r = 21; r <= 23; r++) apply_row(r);

        // tick held high: acceptance after STABLE_TICKS clocks of mismatch, single pulse.
        for (int s = 1; s <= 8; s++) begin
            step(1'b1, 6'h17, 1'b1);
            if (s < 6) chk($sformatf("tickhigh_hold%0d", s), 32'(sw_clean), 32'h15);
            if (s == 6) begin
                chk("tickhigh_accept_clean", 32'(sw_clean), 32'h17);
                chk("tickhigh_accept_pulse", 32'(sw_changed), 32'h02);
            end
            if (s > 6) chk($sformatf("tickhigh_no_repulse%0d", s), 32'(sw_changed), 32'h00);
        end

        // Randomized: periodic tick, constant tick, sparse random tick.
        rnd_raw = sw_raw;
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 250) % 3;
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, (mode == 2) ? 63 : 15) == 0) rnd_raw[b] = ~rnd_raw[b];
            end
            case (mode)
                0:       rnd_tick = (phase == 3);
                1:       rnd_tick = 1'b1;
                default: rnd_tick = ($urandom_range(0, 3) == 0);
            endcase
            phase = (phase + 1) % 4;
            step(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, rnd_raw, rnd_tick);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
